pwm_sample_player: RTL and testbench
====================================

// Module: pwm_sample_player
// PURPOSE
//  Multi-channel PWM playback engine fed from the SDRAM controller read path.
//  Fetches one duty sample per channel each PWM period over a req/ack handshake,
//  double-buffers it and drives glitch-free edge- or centre-aligned PWM outputs.
//  Generalises the single 8-bit PWM/request loop in the top level.
//  Adds channel count, prescaler, aligned mode and underrun detection.
// PARAMETERS
//  DATA_W    8   duty/counter width; MAX = 2^DATA_W-1
//  CHANNELS  2   number of PWM channels
//  DIV       1   prescaler: counter advances once per DIV clocks (DIV>=1)
//  UCNT_W    16  underrun counter width
// PORTS
//  CLK           in   1                system clock (M100CLK domain)
//  reset         in   1                asynchronous, active-low reset
//  enable        in   1                run PWM counter
//  mode          in   1                0 edge-aligned, 1 centre-aligned
//  req           out  1                sample request to controller
//  ack           in   1                sample_in valid; transfer when req&ack
//  sample_in     in   CHANNELS*DATA_W  duties, ch0 in [DATA_W-1:0]
//  underrun_clr  in   1                synchronous clear of underrun_count
//  pwm_out       out  CHANNELS         PWM outputs, registered
//  period_start  out  1                one-cycle pulse at each period boundary
//  underrun      out  1                one-cycle pulse, boundary with no sample
//  underrun_count out UCNT_W           saturating underrun total
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0; counter 0; direction up; prescaler 0.
//   Active/shadow duties are 0, shadow invalid, FSM IDLE, mode_q=0.
//  tick = enable & (prescaler==DIV-1); prescaler wraps 0..DIV-1.
//  enable=0: prescaler, counter and direction are synchronously cleared (0/up).
//   pwm_out is forced 0; no boundaries occur.
//   Active and shadow duties and the FSM are retained.
//  Edge mode: counter 0..MAX, wraps; period = 2^DATA_W ticks.
//  Centre mode: counter counts up 0->MAX, then down to 0; direction flips at MAX and at 0.
//   Period = 2*MAX ticks.
//  Boundary: tick on which the counter returns to 0 (edge: MAX->0; centre: 1->0 going down).
//   period_start pulses on the cycle after the boundary.
//  mode is sampled into mode_q only at boundaries and while enable=0.
//  pwm_out[i] <= (cnt < active[i]), registered; 1-clock latency from counter.
//   duty 0 gives constant 0.
//   Edge duty MAX gives low for 1 tick per period.
//  Request FSM:
//   IDLE: on the first clock after reset release, go to REQ.
//   REQ: req=1. On req&ack, capture sample_in into shadow and set shadow valid.
//    req drops the next cycle; go to FULL.
//   FULL: req=0. At a boundary, active<=shadow, shadow invalid; go to REQ.
//   REQ with a boundary and no ack: underrun pulse; underrun_count++ (saturates at all-ones).
//    active holds; stay in REQ.
//   REQ with ack on the boundary cycle: sample_in loads straight into active, with no underrun.
//    Stay in REQ with req=1 for the next period.
//  underrun_clr sets the count to 0.
//   If it coincides with an underrun, the count becomes 1.
//  ack while req=0 is ignored; sample_in is only sampled when req&ack.
//  Reset mid-operation aborts the handshake immediately.
//   req drops asynchronously; no partial sample is kept.
// TESTING
//  DATA_W=8, CHANNELS=2, DIV=1, edge mode.
//   Ack {C0,40} in the first REQ window.
//   -> From the first boundary, ch0 high 64 of 256 clks and ch1 high 192 of 256, every period.
//  Duty 00/FF. -> ch0 constantly 0; ch1 low exactly 1 clk per 256; period_start every 256 clks.
//  Withhold ack across a boundary.
//   -> underrun pulses 1 clk and underrun_count=1; pwm keeps the previous duties.
//   Then assert underrun_clr. -> count=0.
//  Assert ack on the exact boundary cycle.
//   -> New duty applies that period; underrun stays 0; req remains 1.
//  Centre mode, duty 80.
//   -> period_start every 510 clks; pwm high 255 clks per period, centred on counter 0.
//   With DIV=4, all durations are x4.
//  Pull reset low mid-period with req=1.
//   -> pwm_out, req and underrun_count read 0 before the next CLK edge.
//   After release, req=1 on the 2nd clock.

Source files
------------

// File: rtl/pwm_sample_player.sv
// Multi-channel PWM playback engine: fetches one duty per channel each period over
// a req/ack handshake, double-buffers it and drives edge- or centre-aligned PWM.
module pwm_sample_player #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int DIV      = 1,
    parameter int UCNT_W   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         mode_i,
    output logic                         req_o,
    input  logic                         ack_i,
    input  logic [CHANNELS*DATA_W-1:0]   sample_in_i,
    input  logic                         underrun_clr_i,
    output logic [CHANNELS-1:0]          pwm_out_o,
    output logic                         period_start_o,
    output logic                         underrun_o,
    output logic [UCNT_W-1:0]            underrun_count_o
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [DATA_W-1:0] MAX      = '1;
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

    state_t                           state_q, state_d;
    logic [PRE_W-1:0]                 pre_q, pre_d;
    logic [DATA_W-1:0]                cnt_q, cnt_d;
    logic                             down_q, down_d;
    logic                             mode_q, mode_d;
    logic [CHANNELS-1:0][DATA_W-1:0]  active_q, active_d;
    logic [CHANNELS-1:0][DATA_W-1:0]  shadow_q, shadow_d;
    logic                             shadow_valid_q, shadow_valid_d;
    logic [CHANNELS-1:0]              pwm_q, pwm_d;
    logic                             pstart_q, pstart_d;
    logic                             under_q, under_d;
    logic [UCNT_W-1:0]                ucnt_q, ucnt_d;
    logic                             tick;
    logic                             boundary;

    assign tick     = enable_i && (pre_q == PRE_LAST);
    // A period ends when the counter is about to return to 0.
    assign boundary = tick && (mode_q ? (down_q && (cnt_q == ONE)) : (cnt_q == MAX));

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_pwm
            assign pwm_d[gi] = enable_i && (cnt_q < active_q[gi]);
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        pre_d          = pre_q;
        cnt_d          = cnt_q;
        down_d         = down_q;
        mode_d         = mode_q;
        active_d       = active_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        pstart_d       = boundary;
        under_d        = 1'b0;
        ucnt_d         = ucnt_q;
        req_o          = (state_q == REQ);

        if (!enable_i) begin
            pre_d  = '0;
            cnt_d  = '0;
            down_d = 1'b0;
            mode_d = mode_i;
        end else begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                if (!mode_q) begin
                    cnt_d = cnt_q + ONE;
                end else if (!down_q) begin
                    if (cnt_q == MAX) begin
                        down_d = 1'b1;
                        cnt_d  = cnt_q - ONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else if (cnt_q <= ONE) begin
                    cnt_d  = '0;
                    down_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
                if (boundary) mode_d = mode_i;
            end
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (ack_i) begin
                    // A sample arriving on the boundary itself goes straight to active.
                    if (boundary) begin
                        active_d = sample_in_i;
                    end else begin
                        shadow_d       = sample_in_i;
                        shadow_valid_d = 1'b1;
                        state_d        = FULL;
                    end
                end else if (boundary) begin
                    under_d = 1'b1;
                end
            end
            FULL: begin
                if (boundary && shadow_valid_q) begin
                    active_d       = shadow_q;
                    shadow_valid_d = 1'b0;
                    state_d        = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over accumulation, but a coincident underrun still counts once.
        if (underrun_clr_i) begin
            ucnt_d = under_d ? UCNT_W'(1) : '0;
        end else if (under_d && !(&ucnt_q)) begin
            ucnt_d = ucnt_q + UCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            pre_q          <= '0;
            cnt_q          <= '0;
            down_q         <= 1'b0;
            mode_q         <= 1'b0;
            active_q       <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            pwm_q          <= '0;
            pstart_q       <= 1'b0;
            under_q        <= 1'b0;
            ucnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            down_q         <= down_d;
            mode_q         <= mode_d;
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            pwm_q          <= pwm_d;
            pstart_q       <= pstart_d;
            under_q        <= under_d;
            ucnt_q         <= ucnt_d;
        end
    end

    assign pwm_out_o        = pwm_q;
    assign period_start_o   = pstart_q;
    assign underrun_o       = under_q;
    assign underrun_count_o = ucnt_q;

endmodule

// File: tb/tb_pwm_sample_player.sv
// Bench for pwm_sample_player: per-period duty/length measurement against a queue of
// expected results, plus underrun, boundary-ack, reset and DIV=4 centre-mode sequences.
module tb_pwm_sample_player;

    logic        clk = 1'b0;
    logic        rst_n, enable, mode, ack, clr;
    logic [15:0] sample;
    logic        req1, ps1, ur1, req4, ps4, ur4;
    logic [1:0]  pwm1, pwm4;
    logic [15:0] cnt1, cnt4;
    logic        obs;
    logic        req_m, ps_m, ur_m;
    logic [1:0]  pwm_m;
    logic [15:0] cnt_m;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        md;
        logic [15:0] smp;
        int          hi0;
        int          hi1;
        int          len;
    } vec_t;

    typedef struct {
        int hi0;
        int hi1;
        int len;
    } exp_t;

    vec_t tbl [8];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    pwm_sample_player #(.DATA_W(8), .CHANNELS(2), .DIV(1), .UCNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mode_i(mode),
        .req_o(req1), .ack_i(ack), .sample_in_i(sample), .underrun_clr_i(clr),
        .pwm_out_o(pwm1), .period_start_o(ps1), .underrun_o(ur1),
        .underrun_count_o(cnt1)
    );

    pwm_sample_player #(.DATA_W(8), .CHANNELS(2), .DIV(4), .UCNT_W(16)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mode_i(mode),
        .req_o(req4), .ack_i(ack), .sample_in_i(sample), .underrun_clr_i(clr),
        .pwm_out_o(pwm4), .period_start_o(ps4), .underrun_o(ur4),
        .underrun_count_o(cnt4)
    );

    always_comb begin
        req_m = obs ? req4 : req1;
        ps_m  = obs ? ps4  : ps1;
        ur_m  = obs ? ur4  : ur1;
        pwm_m = obs ? pwm4 : pwm1;
        cnt_m = obs ? cnt4 : cnt1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wait_ps(input int limit);
        int t = 0;
        while (!ps_m && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("period_start_seen", ps_m, 1);
    endtask

    task automatic push_exp(input int hi0, input int hi1, input int len);
        exp_t e;
        e.hi0 = hi0;
        e.hi1 = hi1;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // Measures one period starting right after a period_start pulse.
    task automatic measure(input int ack_k, input logic [15:0] smp, input logic md,
                           input int clr_k, output int hi0, output int hi1, output int len);
        hi0 = 0;
        hi1 = 0;
        len = 0;
        do begin
            @(negedge clk);
            len++;
            if (pwm_m[0]) hi0++;
            if (pwm_m[1]) hi1++;
            if (len == 1) check("underrun_1clk", ur_m, 0);
            if (ack_k > 0 && ack_k < 250 && len == ack_k + 1) check("req_drop", req_m, 0);
            if (clr_k > 0 && clr_k < 250 && len == clr_k + 1) check("clr_count", cnt_m, 0);
            if (len == ack_k) begin
                sample = smp;
                mode   = md;
                ack    = 1'b1;
            end else begin
                ack = 1'b0;
            end
            clr = (len == clr_k);
        end while (!ps_m && len < 5000);
        ack = 1'b0;
        clr = 1'b0;
    endtask

    task automatic pop_cmp(input string name, input int hi0, input int hi1, input int len);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_hi0"}, hi0, e.hi0);
            check({name, "_hi1"}, hi1, e.hi1);
            check({name, "_len"}, len, e.len);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, ln;
        tbl[0] = '{1'b0, 16'hC040,  64, 192, 256};
        tbl[1] = '{1'b0, 16'hC040,  64, 192, 256};
        tbl[2] = '{1'b0, 16'hFF00,   0, 255, 256};
        tbl[3] = '{1'b0, 16'h0180, 128,   1, 256};
        tbl[4] = '{1'b1, 16'h8080, 255, 255, 510};
        tbl[5] = '{1'b1, 16'hFF00,   0, 509, 510};
        tbl[6] = '{1'b1, 16'hFE01,   1, 507, 510};
        tbl[7] = '{1'b0, 16'hC040,  64, 192, 256};

        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; ack = 1'b0; clr = 1'b0;
        sample = '0; obs = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", req1, 0);
        check("rst_pwm", pwm1, 0);
        check("rst_period_start", ps1, 0);
        check("rst_underrun", ur1, 0);
        check("rst_count", cnt1, 0);

        rst_n  = 1'b1;
        enable = 1'b1;
        #1 check("req_before_first_clk", req1, 0);
        @(negedge clk);
        check("req_after_release", req1, 1);

        sample = tbl[0].smp;
        mode   = tbl[0].md;
        ack    = 1'b1;
        push_exp(tbl[0].hi0, tbl[0].hi1, tbl[0].len);
        @(negedge clk);
        ack = 1'b0;
        check("req_drop_first", req1, 0);
        wait_ps(600);

        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                push_exp(tbl[i + 1].hi0, tbl[i + 1].hi1, tbl[i + 1].len);
                measure(1, tbl[i + 1].smp, tbl[i + 1].md, 0, h0, h1, ln);
            end else begin
                measure(0, 16'h0000, 1'b0, 0, h0, h1, ln);
            end
            pop_cmp($sformatf("vec%0d", i), h0, h1, ln);
        end

        // Last vector was not followed by a sample: underrun on that boundary.
        check("underrun_pulse", ur1, 1);
        check("underrun_count_1", cnt1, 1);

        push_exp(tbl[7].hi0, tbl[7].hi1, tbl[7].len);
        measure(0, 16'h0000, 1'b0, 10, h0, h1, ln);
        pop_cmp("hold_after_underrun", h0, h1, ln);
        check("underrun_again", ur1, 1);
        check("count_after_clr_then_underrun", cnt1, 1);

        push_exp(tbl[7].hi0, tbl[7].hi1, tbl[7].len);
        measure(0, 16'h0000, 1'b0, 255, h0, h1, ln);
        pop_cmp("clr_coincide_period", h0, h1, ln);
        check("clr_coincide_underrun", ur1, 1);
        check("clr_coincide_count", cnt1, 1);

        push_exp(tbl[7].hi0, tbl[7].hi1, tbl[7].len);
        measure(255, 16'h2010, 1'b0, 0, h0, h1, ln);
        pop_cmp("boundary_ack_prev", h0, h1, ln);
        check("boundary_ack_no_underrun", ur1, 0);
        check("boundary_ack_req_stays", req1, 1);
        check("boundary_ack_count", cnt1, 1);

        push_exp(16, 32, 256);
        measure(0, 16'h0000, 1'b0, 0, h0, h1, ln);
        pop_cmp("boundary_ack_new", h0, h1, ln);
        check("count_2", cnt1, 2);

        repeat (5) @(negedge clk);
        check("pre_reset_pwm0", pwm1[0], 1);
        check("pre_reset_req", req1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm1, 0);
        check("async_rst_req", req1, 0);
        check("async_rst_count", cnt1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("req_low_at_release", req1, 0);
        @(negedge clk);
        check("req_high_after_release", req1, 1);

        // Centre mode on the DIV=4 instance: mode_q latched while disabled.
        enable = 1'b0;
        mode   = 1'b1;
        obs    = 1'b1;
        @(negedge clk);
        check("div4_req", req4, 1);
        sample = 16'h8080;
        ack    = 1'b1;
        @(negedge clk);
        ack    = 1'b0;
        check("div4_req_drop", req4, 0);
        enable = 1'b1;
        push_exp(1020, 1020, 2040);
        wait_ps(2500);
        measure(1, 16'h8080, 1'b1, 0, h0, h1, ln);
        pop_cmp("div4_centre", h0, h1, ln);
        check("div4_no_underrun", cnt4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
